risc_issue_sequencer: RTL and testbench

//  Multi-cycle issue controller for the RISC opcode decoder. Accepts 8-bit opcodes over a

---
 rtl/risc_seq_pkg.sv | 23 ++
 rtl/risc_seq_timer.sv | 27 ++
 rtl/risc_issue_sequencer.sv | 153 +++++++++++++++
 tb/tb_risc_issue_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_seq_pkg.sv
// Shared types and opcode field positions for the RISC issue sequencer.
package risc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_CTRL = 2'b01,
    CLS_MEM  = 2'b10,
    CLS_SYS  = 2'b11
  } cls_t;

  localparam int OP_CLS_HI  = 7;
  localparam int OP_CLS_LO  = 6;
  localparam int OP_VAR_BIT = 5;  // store for MEM, halt for SYS

  function automatic cls_t op_class(input logic [7:0] op);
    return cls_t'(op[OP_CLS_HI:OP_CLS_LO]);
  endfunction

endpackage

// File: rtl/risc_seq_timer.sv
// Loadable 8-bit down-counter with zero flag; load wins over decrement,
// and the count saturates at zero.
module risc_seq_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] count,
  output logic       zero
);

  logic [7:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_reg <= '0;
    else if (load)
      count_reg <= load_val;
    else if (dec && (count_reg != 8'd0))
      count_reg <= count_reg - 8'd1;
  end

  assign count = count_reg;
  assign zero  = (count_reg == 8'd0);

endmodule

// File: rtl/risc_issue_sequencer.sv
// Multi-cycle issue controller: accepts an opcode, latches the decoder's control
// word, then walks the instruction through EXEC / MEM / WB and counts retires.
module risc_issue_sequencer
  import risc_seq_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ins_valid,
  output logic             ins_ready,
  input  logic [7:0]       ins_opcode,
  output logic [7:0]       dec_opcode,
  input  logic [30:0]      dec_ctl,
  output logic [30:0]      ctl_q,
  output logic             ex_en,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic             wb_en,
  output logic             pc_load,
  input  logic             resume,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [7:0] EXEC_LOAD = 8'(EXEC_CYCLES - 1);
  localparam logic [7:0] MEM_LOAD  = 8'(MEM_TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [7:0]       opcode_reg;
  logic [30:0]      ctl_reg;
  logic [CNT_W-1:0] retire_reg;

  logic       accept, ld_ctl, retire;
  logic       tmr_load, tmr_dec, tmr_zero;
  logic [7:0] tmr_val, tmr_count;
  cls_t       cls;
  logic       variant, store;

  assign cls     = op_class(opcode_reg);
  assign variant = opcode_reg[OP_VAR_BIT];
  assign store   = (cls == CLS_MEM) && variant;

  // One timer serves both the EXEC hold count and the MEM ack timeout.
  risc_seq_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      opcode_reg <= '0;
      ctl_reg    <= '0;
      retire_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept)
        opcode_reg <= ins_opcode;
      if (ld_ctl)
        ctl_reg <= dec_ctl;
      if (retire)
        retire_reg <= retire_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    ld_ctl     = 1'b0;
    retire     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = EXEC_LOAD;
    tmr_dec    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ins_valid) begin
          accept     = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ld_ctl     = 1'b1;
        tmr_load   = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          case (cls)
            CLS_ALU:  state_next = ST_WB;
            CLS_CTRL: begin
              retire     = 1'b1;
              state_next = ST_IDLE;
            end
            CLS_MEM: begin
              tmr_load   = 1'b1;
              tmr_val    = MEM_LOAD;
              state_next = ST_MEM;
            end
            default: begin
              retire     = 1'b1;
              state_next = variant ? ST_HALT : ST_IDLE;
            end
          endcase
        end
      end
      ST_MEM: begin
        // An ack in the last timeout cycle still completes the access.
        if (mem_ack) begin
          retire     = store;
          state_next = store ? ST_IDLE : ST_WB;
        end else if (tmr_zero) begin
          state_next = ST_FAULT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_WB: begin
        retire     = 1'b1;
        state_next = ST_IDLE;
      end
      ST_HALT, ST_FAULT: begin
        if (resume)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign ins_ready  = (state_reg == ST_IDLE);
  assign halted     = (state_reg == ST_HALT);
  assign fault      = (state_reg == ST_FAULT);
  assign dec_opcode = opcode_reg;
  assign ctl_q      = ctl_reg;
  assign retire_cnt = retire_reg;
  assign ex_en      = (state_reg == ST_EXEC);
  assign pc_load    = (state_reg == ST_EXEC) && tmr_zero && (cls == CLS_CTRL);
  assign mem_req    = (state_reg == ST_MEM);
  assign mem_we     = (state_reg == ST_MEM) && store;
  assign wb_en      = (state_reg == ST_WB);

endmodule

// File: tb/tb_risc_issue_sequencer.sv
// Directed bench for risc_issue_sequencer; expected control words go through a
// scoreboard queue and are checked when ex_en first rises for each instruction.
module tb_risc_issue_sequencer;

  localparam int EXEC_CYCLES = 1;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ins_valid = 1'b0;
  logic             ins_ready;
  logic [7:0]       ins_opcode = '0;
  logic [7:0]       dec_opcode;
  logic [30:0]      dec_ctl;
  logic [30:0]      ctl_q;
  logic             ex_en, mem_req, mem_we, wb_en, pc_load, halted, fault;
  logic             mem_ack = 1'b0;
  logic             resume = 1'b0;
  logic [CNT_W-1:0] retire_cnt;

  int tests_run = 0;
  int failed    = 0;
  logic [30:0] sb_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic ex_en_d = 1'b0;

  always #5 clk = ~clk;

  // Stand-in for the external decoder: any deterministic, non-trivial mapping.
  function automatic logic [30:0] ctl_of(input logic [7:0] op);
    return {op[6:0], ~op, op, op ^ 8'h5A};
  endfunction

  assign dec_ctl = ctl_of(dec_opcode);

  risc_issue_sequencer #(
    .EXEC_CYCLES (EXEC_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins_opcode (ins_opcode),
    .dec_opcode (dec_opcode),
    .dec_ctl    (dec_ctl),
    .ctl_q      (ctl_q),
    .ex_en      (ex_en),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_ack    (mem_ack),
    .wb_en      (wb_en),
    .pc_load    (pc_load),
    .resume     (resume),
    .halted     (halted),
    .fault      (fault),
    .retire_cnt (retire_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0: offer the opcode; returns one cycle later (cycle 1, DECODE).
  task automatic issue(input logic [7:0] op);
    ins_opcode = op;
    ins_valid  = 1'b1;
    chk("accept_ready", {31'd0, ins_ready}, 32'd1);
    sb_q.push_back(ctl_of(op));
    step();
    ins_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      ex_en_d <= 1'b0;
    end else begin
      if (ex_en && !ex_en_d) begin
        if (sb_q.size() == 0) begin
          tests_run++;
          failed++;
          $error("FAIL sb_underflow observed=ex_en expected=no_instruction");
        end else begin
          chk("ctl_q", {1'b0, ctl_q}, {1'b0, sb_q.pop_front()});
        end
      end
      ex_en_d <= ex_en;
    end
  end

  initial begin
    // Reset
    step();
    chk("rst_ready", {31'd0, ins_ready}, 32'd1);
    chk("rst_ctl_q", {1'b0, ctl_q}, 32'd0);
    chk("rst_cnt", {28'd0, retire_cnt}, 32'd0);
    chk("rst_strobes", {26'd0, ex_en, mem_req, wb_en, pc_load, halted, fault}, 32'd0);
    chk("rst_dec_opcode", {24'd0, dec_opcode}, 32'd0);
    rst_n = 1'b1;
    step();

    // ALU 8'h20
    issue(8'h20);
    chk("alu_c1_ex_en", {31'd0, ex_en}, 32'd0);
    step();
    chk("alu_c2_ex_en", {31'd0, ex_en}, 32'd1);
    chk("alu_c2_dec_opcode", {24'd0, dec_opcode}, 32'h20);
    step();
    chk("alu_c3_wb_en", {31'd0, wb_en}, 32'd1);
    chk("alu_c3_ready", {31'd0, ins_ready}, 32'd0);
    step();
    exp_cnt = exp_cnt + 1'b1;
    chk("alu_c4_ready", {31'd0, ins_ready}, 32'd1);
    chk("alu_c4_wb_en", {31'd0, wb_en}, 32'd0);
    chk("alu_cnt", {28'd0, retire_cnt}, {28'd0, exp_cnt});

    // Load 8'h80, ack in cycle 5
    issue(8'h80);
    step();
    step();
    chk("ld_c3_req_we", {30'd0, mem_req, mem_we}, 32'b10);
    step();
    chk("ld_c4_req", {31'd0, mem_req}, 32'd1);
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("ld_c6_wb_en", {31'd0, wb_en}, 32'd1);
    chk("ld_c6_req", {31'd0, mem_req}, 32'd0);
    step();
    exp_cnt = exp_cnt + 1'b1;
    chk("ld_c7_ready", {31'd0, ins_ready}, 32'd1);
    chk("ld_cnt", {28'd0, retire_cnt}, {28'd0, exp_cnt});

    // Store 8'hA0 with no ack: four MEM cycles then FAULT
    issue(8'hA0);
    step();
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      step();
      chk("st_to_req_we", {30'd0, mem_req, mem_we}, 32'b11);
      chk("st_to_fault", {31'd0, fault}, 32'd0);
    end
    step();
    chk("st_to_fault_set", {31'd0, fault}, 32'd1);
    chk("st_to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("st_to_cnt", {28'd0, retire_cnt}, {28'd0, exp_cnt});
    step();
    chk("st_to_fault_hold", {31'd0, fault}, 32'd1);
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("st_to_resume_fault", {31'd0, fault}, 32'd0);
    chk("st_to_resume_ready", {31'd0, ins_ready}, 32'd1);

    // Store with ack in the final MEM cycle: ack beats timeout
    issue(8'hA0);
    step();
    step();
    step();
    step();
    step();
    mem_ack = 1'b1;
    chk("st_last_req", {31'd0, mem_req}, 32'd1);
    step();
    mem_ack = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    chk("st_last_fault", {31'd0, fault}, 32'd0);
    chk("st_last_ready", {31'd0, ins_ready}, 32'd1);
    chk("st_last_cnt", {28'd0, retire_cnt}, {28'd0, exp_cnt});

    // CTRL 8'h40: one-cycle pc_load, no writeback
    issue(8'h40);
    step();
    chk("ctrl_c2_pc_ex", {30'd0, pc_load, ex_en}, 32'b11);
    chk("ctrl_c2_wb_en", {31'd0, wb_en}, 32'd0);
    step();
    exp_cnt = exp_cnt + 1'b1;
    chk("ctrl_c3_pc_wb", {30'd0, pc_load, wb_en}, 32'b00);
    chk("ctrl_c3_ready", {31'd0, ins_ready}, 32'd1);
    chk("ctrl_cnt", {28'd0, retire_cnt}, {28'd0, exp_cnt});

    // SYS 8'hE0: halt, retire on entry, ignore fetch while halted
    issue(8'hE0);
    step();
    step();
    exp_cnt = exp_cnt + 1'b1;
    chk("halt_set", {31'd0, halted}, 32'd1);
    chk("halt_cnt", {28'd0, retire_cnt}, {28'd0, exp_cnt});
    ins_opcode = 8'h00;
    ins_valid  = 1'b1;
    chk("halt_not_ready", {31'd0, ins_ready}, 32'd0);
    step();
    ins_valid = 1'b0;
    chk("halt_hold", {31'd0, halted}, 32'd1);
    chk("halt_dec_opcode", {24'd0, dec_opcode}, 32'hE0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("halt_resume", {31'd0, halted}, 32'd0);
    chk("halt_resume_ready", {31'd0, ins_ready}, 32'd1);

    // SYS 8'hC0: back to IDLE without halting
    issue(8'hC0);
    step();
    chk("sys_c2_ex_en", {31'd0, ex_en}, 32'd1);
    step();
    exp_cnt = exp_cnt + 1'b1;
    chk("sys_c3_ready_halt", {30'd0, ins_ready, halted}, 32'b10);
    chk("sys_cnt", {28'd0, retire_cnt}, {28'd0, exp_cnt});

    // Run ALU ops until the 4-bit retire counter wraps after 16 retires
    for (int i = 0; i < 10; i++) begin
      issue(8'(i * 5));
      step();
      step();
      chk("wrap_wb_en", {31'd0, wb_en}, 32'd1);
      step();
      exp_cnt = exp_cnt + 1'b1;
      chk("wrap_cnt", {28'd0, retire_cnt}, {28'd0, exp_cnt});
    end
    chk("wrap_zero", {28'd0, retire_cnt}, 32'd0);

    // Asynchronous reset while a load waits in MEM
    issue(8'h80);
    step();
    step();
    chk("arst_req_before", {31'd0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_drop", {31'd0, mem_req}, 32'd0);
    chk("arst_ready", {31'd0, ins_ready}, 32'd1);
    chk("arst_ctl_q", {1'b0, ctl_q}, 32'd0);
    chk("arst_dec_opcode", {24'd0, dec_opcode}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_idle", {31'd0, ins_ready}, 32'd1);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
